// File: rtl/raw_mem_release_tracker_pkg.sv
// Shared types and default widths for the RAW memory release tracker.
package raw_mem_pkg;

  localparam int ENTRY_NUM_BITS_DEF = 4;
  localparam int TAG_BITS_DEF       = 3;

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } slot_state_t;

endpackage

// File: rtl/raw_mem_release_tracker_if.sv
// Issue, completion and scoreboard-pulse signals of the release tracker.
interface raw_mem_release_tracker_if
  import raw_mem_pkg::*;
#(
  parameter int ENTRY_NUM_BITS = ENTRY_NUM_BITS_DEF,
  parameter int TAG_BITS       = TAG_BITS_DEF
);

  logic                      issue_vld;
  logic [ENTRY_NUM_BITS-1:0] issue_num;
  logic                      issue_rdy;
  logic [TAG_BITS-1:0]       issue_tag;
  logic                      cmp_a_vld;
  logic [TAG_BITS-1:0]       cmp_a_tag;
  logic                      cmp_b_vld;
  logic [TAG_BITS-1:0]       cmp_b_tag;
  logic                      ins_add_1_vld;
  logic [ENTRY_NUM_BITS-1:0] ins_add_1_num;
  logic                      ins_minus_1_vld;
  logic [ENTRY_NUM_BITS-1:0] ins_minus_1_num;
  logic [TAG_BITS:0]         busy_cnt;
  logic                      err_bad_tag;

  modport master (
    output issue_vld, issue_num, cmp_a_vld, cmp_a_tag, cmp_b_vld, cmp_b_tag,
    input  issue_rdy, issue_tag, ins_add_1_vld, ins_add_1_num,
           ins_minus_1_vld, ins_minus_1_num, busy_cnt, err_bad_tag
  );

  modport slave (
    input  issue_vld, issue_num, cmp_a_vld, cmp_a_tag, cmp_b_vld, cmp_b_tag,
    output issue_rdy, issue_tag, ins_add_1_vld, ins_add_1_num,
           ins_minus_1_vld, ins_minus_1_num, busy_cnt, err_bad_tag
  );

endinterface

// File: rtl/raw_mem_release_tracker_fifo.sv
// Release FIFO of completed slot tags: two pushes (A then B) and one pop per cycle.
module raw_mem_release_fifo
  import raw_mem_pkg::*;
#(
  parameter int TAG_BITS = TAG_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_a,
  input  logic [TAG_BITS-1:0] push_a_tag,
  input  logic                push_b,
  input  logic [TAG_BITS-1:0] push_b_tag,
  input  logic                pop,
  output logic [TAG_BITS-1:0] head_tag,
  output logic                empty
);

  localparam int DEPTH = 1 << TAG_BITS;
  localparam int CW    = TAG_BITS + 1;

  logic [TAG_BITS-1:0] mem_reg [DEPTH];
  logic [TAG_BITS-1:0] wr_ptr_reg;
  logic [TAG_BITS-1:0] rd_ptr_reg;
  logic [CW-1:0]       count_reg;
  logic [TAG_BITS-1:0] wr_ptr_b;
  logic                pop_eff;

  assign empty    = (count_reg == '0);
  assign pop_eff  = pop && !empty;
  assign head_tag = mem_reg[rd_ptr_reg];
  // B lands behind A when both push in the same cycle.
  assign wr_ptr_b = push_a ? wr_ptr_reg + 1'b1 : wr_ptr_reg;

  always_ff @(posedge clk) begin
    if (push_a) mem_reg[wr_ptr_reg] <= push_a_tag;
    if (push_b) mem_reg[wr_ptr_b]   <= push_b_tag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + TAG_BITS'(push_a) + TAG_BITS'(push_b);
      rd_ptr_reg <= rd_ptr_reg + TAG_BITS'(pop_eff);
      count_reg  <= count_reg + CW'(push_a) + CW'(push_b) - CW'(pop_eff);
    end
  end

endmodule

// File: rtl/raw_mem_release_tracker.sv
// Slot table tracking in-flight memory writes; emits one add per issue and one minus per completion.
module raw_mem_release_tracker
  import raw_mem_pkg::*;
#(
  parameter int ENTRY_NUM_BITS = ENTRY_NUM_BITS_DEF,
  parameter int TAG_BITS       = TAG_BITS_DEF
) (
  input  logic clk,
  input  logic rst,
  raw_mem_release_tracker_if.slave bus
);

  localparam int SLOTS = 1 << TAG_BITS;
  localparam int CW    = TAG_BITS + 1;

  slot_state_t               slot_state_reg  [SLOTS];
  slot_state_t               slot_state_next [SLOTS];
  logic [ENTRY_NUM_BITS-1:0] slot_num_reg    [SLOTS];

  logic [SLOTS-1:0]    free_vec;
  logic [SLOTS-1:0]    alloc_hit;
  logic [SLOTS-1:0]    done_hit;
  logic [SLOTS-1:0]    rel_hit;
  logic [TAG_BITS-1:0] alloc_tag;
  logic [TAG_BITS-1:0] pop_tag;
  logic                issue_rdy;
  logic                accept;
  logic                same_tag;
  logic                a_ok;
  logic                b_ok;
  logic                fifo_empty;
  logic                pop;
  logic                err_next;
  logic [CW-1:0]       busy_cnt_next;

  logic                      add_vld_reg;
  logic [ENTRY_NUM_BITS-1:0] add_num_reg;
  logic                      minus_vld_reg;
  logic [ENTRY_NUM_BITS-1:0] minus_num_reg;
  logic [CW-1:0]             busy_cnt_reg;
  logic                      err_reg;

  assign accept   = bus.issue_vld && issue_rdy;
  assign pop      = !fifo_empty;
  assign same_tag = (bus.cmp_a_tag == bus.cmp_b_tag);
  // A slot allocated this cycle is still FREE here, so a completion to it is rejected.
  assign a_ok     = bus.cmp_a_vld && (slot_state_reg[bus.cmp_a_tag] == BUSY);
  assign b_ok     = bus.cmp_b_vld && (slot_state_reg[bus.cmp_b_tag] == BUSY) && !(a_ok && same_tag);
  assign err_next = (bus.cmp_a_vld && !a_ok) || (bus.cmp_b_vld && !b_ok);

  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
    assign free_vec[gi]  = (slot_state_reg[gi] == FREE);
    assign alloc_hit[gi] = accept && (alloc_tag == TAG_BITS'(gi));
    assign done_hit[gi]  = (a_ok && (bus.cmp_a_tag == TAG_BITS'(gi)))
                        || (b_ok && (bus.cmp_b_tag == TAG_BITS'(gi)));
    assign rel_hit[gi]   = pop && (pop_tag == TAG_BITS'(gi));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) slot_state_reg[i] <= FREE;
    end else begin
      slot_state_reg <= slot_state_next;
    end
  end

  always_comb begin
    for (int i = 0; i < SLOTS; i++) begin
      slot_state_next[i] = slot_state_reg[i];
      case (slot_state_reg[i])
        FREE:    if (alloc_hit[i]) slot_state_next[i] = BUSY;
        BUSY:    if (done_hit[i])  slot_state_next[i] = DRAIN;
        DRAIN:   if (rel_hit[i])   slot_state_next[i] = FREE;
        default: slot_state_next[i] = FREE;
      endcase
    end
  end

  // Lowest-index FREE slot wins allocation.
  always_comb begin
    alloc_tag = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (free_vec[i]) alloc_tag = TAG_BITS'(i);
    end
    issue_rdy = |free_vec;
  end

  always_ff @(posedge clk) begin
    if (accept) slot_num_reg[alloc_tag] <= bus.issue_num;
  end

  raw_mem_release_fifo #(
    .TAG_BITS (TAG_BITS)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_a     (a_ok),
    .push_a_tag (bus.cmp_a_tag),
    .push_b     (b_ok),
    .push_b_tag (bus.cmp_b_tag),
    .pop        (pop),
    .head_tag   (pop_tag),
    .empty      (fifo_empty)
  );

  assign busy_cnt_next = busy_cnt_reg + CW'(accept) - CW'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      add_vld_reg   <= 1'b0;
      add_num_reg   <= '0;
      minus_vld_reg <= 1'b0;
      minus_num_reg <= '0;
      busy_cnt_reg  <= '0;
      err_reg       <= 1'b0;
    end else begin
      add_vld_reg   <= accept;
      if (accept) add_num_reg <= bus.issue_num;
      minus_vld_reg <= pop;
      if (pop) minus_num_reg <= slot_num_reg[pop_tag];
      busy_cnt_reg  <= busy_cnt_next;
      err_reg       <= err_next;
    end
  end

  assign bus.issue_rdy       = issue_rdy;
  assign bus.issue_tag       = alloc_tag;
  assign bus.ins_add_1_vld   = add_vld_reg;
  assign bus.ins_add_1_num   = add_num_reg;
  assign bus.ins_minus_1_vld = minus_vld_reg;
  assign bus.ins_minus_1_num = minus_num_reg;
  assign bus.busy_cnt        = busy_cnt_reg;
  assign bus.err_bad_tag     = err_reg;

endmodule

// File: tb/tb_raw_mem_release_tracker.sv
// Directed bench: expected add/minus/error pulses are queued at stimulus time and checked by a monitor.
module tb_raw_mem_release_tracker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   add_q[$];
  int   minus_q[$];
  int   err_q[$];

  always #5 clk = ~clk;

  raw_mem_release_tracker_if #(.ENTRY_NUM_BITS(4), .TAG_BITS(3)) bus ();

  raw_mem_release_tracker #(.ENTRY_NUM_BITS(4), .TAG_BITS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.issue_vld = 1'b0;
    bus.issue_num = '0;
    bus.cmp_a_vld = 1'b0;
    bus.cmp_a_tag = '0;
    bus.cmp_b_vld = 1'b0;
    bus.cmp_b_tag = '0;
  endtask

  // Monitor: every pulse must match the head of its expectation queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ins_add_1_vld) begin
        if (add_q.size() == 0) chk("add_unexpected_num", int'(bus.ins_add_1_num), -1);
        else chk("add_num", int'(bus.ins_add_1_num), add_q.pop_front());
      end
      if (bus.ins_minus_1_vld) begin
        if (minus_q.size() == 0) chk("minus_unexpected_num", int'(bus.ins_minus_1_num), -1);
        else chk("minus_num", int'(bus.ins_minus_1_num), minus_q.pop_front());
      end
      if (bus.err_bad_tag) begin
        if (err_q.size() == 0) chk("err_unexpected", 1, 0);
        else chk("err_bad_tag", 1, err_q.pop_front());
      end
    end
  end

  initial begin
    idle_inputs();
    #1;
    chk("rst_busy_cnt", int'(bus.busy_cnt), 0);
    chk("rst_add_vld", int'(bus.ins_add_1_vld), 0);
    tick();
    tick();
    rst = 1'b0;
    chk("rst_issue_rdy", int'(bus.issue_rdy), 1);
    chk("rst_issue_tag", int'(bus.issue_tag), 0);
    chk("rst_minus_vld", int'(bus.ins_minus_1_vld), 0);
    chk("rst_err", int'(bus.err_bad_tag), 0);

    // 1: first issue takes slot 0
    bus.issue_vld = 1'b1; bus.issue_num = 4'd5; #1;
    chk("t1_issue_tag", int'(bus.issue_tag), 0);
    add_q.push_back(5);
    tick();
    idle_inputs();
    chk("t1_add_vld", int'(bus.ins_add_1_vld), 1);
    chk("t1_busy_cnt", int'(bus.busy_cnt), 1);

    // 2: completion at C, minus at C+2
    bus.cmp_a_vld = 1'b1; bus.cmp_a_tag = 3'd0;
    minus_q.push_back(5);
    tick();
    idle_inputs();
    chk("t2_minus_vld_c1", int'(bus.ins_minus_1_vld), 0);
    chk("t2_busy_cnt_c1", int'(bus.busy_cnt), 1);
    tick();
    chk("t2_minus_vld_c2", int'(bus.ins_minus_1_vld), 1);
    chk("t2_busy_cnt_c2", int'(bus.busy_cnt), 0);
    tick();

    // 3: fill all 8 slots, 9th issue ignored
    for (int i = 0; i < 8; i++) begin
      bus.issue_vld = 1'b1; bus.issue_num = 4'(i); #1;
      chk("t3_issue_tag", int'(bus.issue_tag), i);
      add_q.push_back(i);
      tick();
    end
    bus.issue_vld = 1'b1; bus.issue_num = 4'd12; #1;
    chk("t3_full_rdy", int'(bus.issue_rdy), 0);
    tick();
    idle_inputs();
    chk("t3_full_no_add", int'(bus.ins_add_1_vld), 0);
    chk("t3_full_busy_cnt", int'(bus.busy_cnt), 8);
    for (int i = 0; i < 8; i += 2) begin
      bus.cmp_a_vld = 1'b1; bus.cmp_a_tag = 3'(i);
      bus.cmp_b_vld = 1'b1; bus.cmp_b_tag = 3'(i + 1);
      minus_q.push_back(i);
      minus_q.push_back(i + 1);
      tick();
    end
    idle_inputs();
    repeat (10) tick();
    chk("t3_drained_busy_cnt", int'(bus.busy_cnt), 0);

    // 4: slots 0..3 get nums 1,2,9,4; complete A=3, B=2 together
    bus.issue_vld = 1'b1; bus.issue_num = 4'd1; add_q.push_back(1); tick();
    bus.issue_num = 4'd2; add_q.push_back(2); tick();
    bus.issue_num = 4'd9; add_q.push_back(9); tick();
    bus.issue_num = 4'd4; add_q.push_back(4); tick();
    idle_inputs();
    bus.cmp_a_vld = 1'b1; bus.cmp_a_tag = 3'd3;
    bus.cmp_b_vld = 1'b1; bus.cmp_b_tag = 3'd2;
    minus_q.push_back(4);
    minus_q.push_back(9);
    tick();
    idle_inputs();
    tick();
    chk("t4_minus_vld_c2", int'(bus.ins_minus_1_vld), 1);
    chk("t4_minus_num_c2", int'(bus.ins_minus_1_num), 4);
    tick();
    chk("t4_minus_vld_c3", int'(bus.ins_minus_1_vld), 1);
    chk("t4_minus_num_c3", int'(bus.ins_minus_1_num), 9);
    tick();
    chk("t4_busy_cnt", int'(bus.busy_cnt), 2);

    // 5: completion to FREE slot 6, then A=B=slot 1 (num 2)
    bus.cmp_a_vld = 1'b1; bus.cmp_a_tag = 3'd6;
    err_q.push_back(1);
    tick();
    idle_inputs();
    chk("t5_err_free", int'(bus.err_bad_tag), 1);
    bus.cmp_a_vld = 1'b1; bus.cmp_a_tag = 3'd1;
    bus.cmp_b_vld = 1'b1; bus.cmp_b_tag = 3'd1;
    err_q.push_back(1);
    minus_q.push_back(2);
    tick();
    idle_inputs();
    chk("t5_err_same", int'(bus.err_bad_tag), 1);
    tick();
    chk("t5_err_clear", int'(bus.err_bad_tag), 0);
    bus.cmp_a_vld = 1'b1; bus.cmp_a_tag = 3'd0;
    minus_q.push_back(1);
    tick();
    idle_inputs();
    repeat (5) tick();
    chk("t5_busy_cnt", int'(bus.busy_cnt), 0);
    // completion to the slot being allocated in the same cycle
    bus.issue_vld = 1'b1; bus.issue_num = 4'd3;
    bus.cmp_a_vld = 1'b1; bus.cmp_a_tag = 3'd0;
    add_q.push_back(3);
    err_q.push_back(1);
    tick();
    idle_inputs();
    chk("t5_alloc_same_busy", int'(bus.busy_cnt), 1);

    // 6: three busy, two queued for release, then reset
    bus.issue_vld = 1'b1; bus.issue_num = 4'd7; add_q.push_back(7); tick();
    bus.issue_num = 4'd8; add_q.push_back(8); tick();
    idle_inputs();
    bus.cmp_a_vld = 1'b1; bus.cmp_a_tag = 3'd1;
    bus.cmp_b_vld = 1'b1; bus.cmp_b_tag = 3'd2;
    tick();
    idle_inputs();
    rst = 1'b1;
    #1;
    chk("t6_add_vld", int'(bus.ins_add_1_vld), 0);
    chk("t6_minus_vld", int'(bus.ins_minus_1_vld), 0);
    chk("t6_minus_num", int'(bus.ins_minus_1_num), 0);
    chk("t6_busy_cnt", int'(bus.busy_cnt), 0);
    chk("t6_err", int'(bus.err_bad_tag), 0);
    chk("t6_issue_tag", int'(bus.issue_tag), 0);
    chk("t6_issue_rdy", int'(bus.issue_rdy), 1);
    tick();
    tick();
    rst = 1'b0;
    repeat (6) tick();
    chk("t6_post_busy_cnt", int'(bus.busy_cnt), 0);

    chk("end_add_q_empty", add_q.size(), 0);
    chk("end_minus_q_empty", minus_q.size(), 0);
    chk("end_err_q_empty", err_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
